// File: rtl/d_branch_unit.sv
// Decode-stage branch resolution with a 2-bit-counter BHT predictor,
// registered link bookkeeping for the E stage and branch statistics.
module d_branch_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D_CMP_A,
  input  logic [WIDTH-1:0] D_CMP_B,
  input  logic [3:0]       D_CMPop,
  input  logic             D_valid,
  input  logic             D_stall,
  input  logic [WIDTH-1:0] D_pc,
  input  logic [15:0]      D_imm16,
  input  logic             D_pred_taken,
  input  logic [WIDTH-1:0] F_pc,
  output logic             F_pred_taken,
  output logic             D_cmp_sig,
  output logic [WIDTH-1:0] D_target,
  output logic             D_mispredict,
  output logic             E_valid,
  output logic             E_link,
  output logic [WIDTH-1:0] E_link_addr,
  output logic [31:0]      br_count,
  output logic [31:0]      mp_count
);

  localparam int IW = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic             is_br;
  logic             sign_a;
  logic             zero_a;
  logic             eq_ab;
  logic             cond;
  logic             upd;
  logic             link_op;
  logic [IW-1:0]    d_idx;
  logic [IW-1:0]    f_idx;
  logic [1:0]       cur;
  logic [1:0]       nxt;
  logic signed [17:0] off18;
  logic [WIDTH-1:0] off;

  assign is_br  = ~D_CMPop[3];
  assign sign_a = D_CMP_A[WIDTH-1];
  assign zero_a = (D_CMP_A == '0);
  assign eq_ab  = (D_CMP_A == D_CMP_B);

  always_comb begin
    cond = 1'b0;
    case (D_CMPop)
      4'd0:    cond = eq_ab;
      4'd1:    cond = sign_a;
      4'd2:    cond = ~eq_ab;
      4'd3:    cond = sign_a | zero_a;
      4'd4:    cond = ~sign_a & ~zero_a;
      4'd5:    cond = sign_a;
      4'd6:    cond = ~sign_a;
      4'd7:    cond = ~sign_a;
      default: cond = 1'b0;
    endcase
  end

  assign D_cmp_sig    = cond & D_valid;
  assign D_mispredict = D_valid & is_br & (cond != D_pred_taken);

  // Offset is sign-extended (or truncated for narrow datapaths) to WIDTH.
  assign off18    = {D_imm16, 2'b00};
  assign off      = WIDTH'(off18);
  assign D_target = D_pc + WIDTH'(4) + off;

  assign d_idx = D_pc[IW+1:2];
  assign f_idx = F_pc[IW+1:2];

  // No bypass: the fetch side sees the entry before this edge's update.
  assign F_pred_taken = ~reset & bht[f_idx][1];

  assign upd     = D_valid & ~D_stall & is_br;
  assign link_op = (D_CMPop == 4'd1) | (D_CMPop == 4'd7);
  assign cur     = bht[d_idx];

  always_comb begin
    nxt = cur;
    if (cond) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (upd) begin
      bht[d_idx] <= nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (upd) begin
      br_count <= br_count + 32'd1;
      if (D_mispredict) mp_count <= mp_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_valid     <= 1'b0;
      E_link      <= 1'b0;
      E_link_addr <= '0;
    end else if (D_stall || !D_valid) begin
      E_valid     <= 1'b0;
      E_link      <= 1'b0;
      E_link_addr <= '0;
    end else begin
      E_valid     <= 1'b1;
      E_link      <= link_op;
      E_link_addr <= D_pc + WIDTH'(8);
    end
  end

endmodule

// File: tb/tb_d_branch_unit.sv
// Bench for d_branch_unit: behavioural predictor model plus directed
// literal checks, with a narrow second instance for the wrap case.
module tb_d_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a, b, pc, fpc;
  logic [3:0]  op;
  logic        v, st, pr;
  logic [15:0] imm;
  logic        cmp, mpr, fp, ev, el;
  logic [31:0] tgt, ela, brc, mpc;

  logic [15:0] a1, b1, pc1, fpc1, tgt1, ela1;
  logic [3:0]  op1;
  logic        v1, st1, pr1;
  logic [15:0] imm1;
  logic        fp1, cmp1, mp1, ev1, el1;
  logic [31:0] brc1, mpc1;

  int checks = 0;
  int failures = 0;

  d_branch_unit u0 (
    .clk(clk), .reset(reset),
    .D_CMP_A(a), .D_CMP_B(b), .D_CMPop(op),
    .D_valid(v), .D_stall(st), .D_pc(pc), .D_imm16(imm),
    .D_pred_taken(pr), .F_pc(fpc), .F_pred_taken(fp),
    .D_cmp_sig(cmp), .D_target(tgt), .D_mispredict(mpr),
    .E_valid(ev), .E_link(el), .E_link_addr(ela),
    .br_count(brc), .mp_count(mpc)
  );

  d_branch_unit #(.WIDTH(16), .BHT_DEPTH(4)) u1 (
    .clk(clk), .reset(reset),
    .D_CMP_A(a1), .D_CMP_B(b1), .D_CMPop(op1),
    .D_valid(v1), .D_stall(st1), .D_pc(pc1), .D_imm16(imm1),
    .D_pred_taken(pr1), .F_pc(fpc1), .F_pred_taken(fp1),
    .D_cmp_sig(cmp1), .D_target(tgt1), .D_mispredict(mp1),
    .E_valid(ev1), .E_link(el1), .E_link_addr(ela1),
    .br_count(brc1), .mp_count(mpc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: counters as plain ints, signed compares on longints.
  int          m_bht [16];
  int unsigned m_br, m_mp;
  bit          m_ev, m_el;
  logic [31:0] m_ela;

  function automatic bit m_cond(input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] y);
    longint sx;
    sx = longint'($signed(x));
    case (o)
      4'd0:       return x == y;
      4'd1, 4'd5: return sx < 0;
      4'd2:       return x != y;
      4'd3:       return sx <= 0;
      4'd4:       return sx > 0;
      4'd6, 4'd7: return sx >= 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int m_idx(input logic [31:0] p);
    return int'((p >> 2) % 16);
  endfunction

  function automatic logic [31:0] m_tgt(input logic [31:0] p,
                                        input logic [15:0] im);
    int off;
    off = int'($signed(im)) * 4;
    return p + 32'd4 + 32'(off);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_br = 0; m_mp = 0; m_ev = 0; m_el = 0; m_ela = 0;
    end else begin
      if (v && !st && op < 8) begin
        bit c;
        c = m_cond(op, a, b);
        if (c) m_bht[m_idx(pc)] = (m_bht[m_idx(pc)] == 3) ? 3 : m_bht[m_idx(pc)] + 1;
        else   m_bht[m_idx(pc)] = (m_bht[m_idx(pc)] == 0) ? 0 : m_bht[m_idx(pc)] - 1;
        m_br++;
        if (c != pr) m_mp++;
      end
      m_ev  = v && !st;
      m_el  = m_ev && (op == 1 || op == 7);
      m_ela = m_ev ? pc + 32'd8 : 32'd0;
    end
  end

  always @(negedge clk) begin
    bit c;
    c = m_cond(op, a, b);
    chk("cmp_sig", cmp, 32'(v & c));
    chk("target", tgt, m_tgt(pc, imm));
    chk("mispredict", mpr, 32'(v && op < 8 && c != pr));
    chk("f_pred", fp, 32'(!reset && m_bht[m_idx(fpc)] >= 2));
    chk("e_valid", ev, 32'(m_ev));
    chk("e_link", el, 32'(m_el));
    chk("e_link_addr", ela, m_ela);
    chk("br_count", brc, m_br);
    chk("mp_count", mpc, m_mp);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic vv,
                       input logic ss, input logic [31:0] p,
                       input logic [15:0] im, input logic pp);
    op = o; a = aa; b = bb; v = vv; st = ss; pc = p; imm = im; pr = pp;
  endtask

  bit          exp_up [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  bit          exp_dn [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] av [3] = '{32'h8000_0000, 32'h0, 32'h1};
  logic [7:0]  tab [3] = '{8'h2E, 8'hC9, 8'hD4};

  initial begin
    drive(4'd0, 0, 0, 0, 0, 0, 0, 0);
    fpc = 0;
    a1 = 0; b1 = 0; op1 = 0; v1 = 0; st1 = 0; pc1 = 0; imm1 = 0;
    pr1 = 0; fpc1 = 0;
    reset = 1'b1;
    #2;
    chk("rst_br", brc, 0);
    chk("rst_mp", mpc, 0);
    chk("rst_ev", ev, 0);
    chk("rst_fp", fp, 0);
    tick;
    reset = 1'b0;

    drive(4'd0, 5, 5, 1, 0, 32'h100, 16'hFFFF, 0);
    fpc = 32'h100;
    #1;
    chk("t1_cmp", cmp, 1);
    chk("t1_tgt", tgt, 32'h100);
    chk("t1_mp", mpr, 1);
    chk("t1_fp_pre", fp, 0);
    tick;
    chk("t1_br", brc, 1);
    chk("t1_mpc", mpc, 1);
    chk("t1_fp_post", fp, 1);

    fpc = 32'h44;
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 7, 7, 1, 0, 32'h44, 0, 1);
      #1;
      chk("sat_up_pre", fp, 32'(exp_up[i]));
      tick;
    end
    chk("sat_up_end", fp, 1);
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 7, 8, 1, 0, 32'h44, 0, 0);
      #1;
      chk("sat_dn_pre", fp, 32'(exp_dn[i]));
      tick;
    end
    chk("sat_dn_end", fp, 0);

    for (int j = 0; j < 3; j++) begin
      for (int o = 0; o < 8; o++) begin
        drive(4'(o), av[j], 0, 1, 1, 32'h300, 16'd4, 0);
        #1;
        chk("sweep_cmp", cmp, 32'(tab[j][o]));
        tick;
      end
    end

    drive(4'd9, 0, 0, 1, 0, 32'h300, 0, 1);
    #1;
    chk("op9_cmp", cmp, 0);
    chk("op9_mp", mpr, 0);
    tick;
    chk("op9_br", brc, 9);
    chk("op9_mpc", mpc, 1);

    drive(4'd1, 1, 0, 1, 0, 32'h200, 0, 0);
    tick;
    chk("link_ev", ev, 1);
    chk("link_el", el, 1);
    chk("link_addr", ela, 32'h208);
    chk("link_br", brc, 10);
    drive(4'd1, 1, 0, 1, 1, 32'h200, 0, 0);
    tick;
    chk("stall_ev", ev, 0);
    chk("stall_el", el, 0);
    chk("stall_addr", ela, 0);
    chk("stall_br", brc, 10);

    repeat (400) begin
      logic [31:0] ra;
      logic [31:0] rb;
      rb = (($urandom % 4) == 0) ? 32'h0 : 32'($urandom);
      case ($urandom % 5)
        0: ra = 32'h0;
        1: ra = 32'h1;
        2: ra = 32'h8000_0000;
        3: ra = rb;
        default: ra = 32'($urandom);
      endcase
      drive(4'($urandom), ra, rb, ($urandom % 8) != 0,
            ($urandom % 4) == 0, {24'($urandom), 6'($urandom), 2'b00},
            16'($urandom), 1'($urandom));
      fpc = {26'($urandom), 4'($urandom), 2'b00};
      tick;
    end

    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 1, 1, 1, 0, 32'h10, 0, 0);
      tick;
    end
    drive(4'd15, 0, 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_br", brc, 0);
    chk("mid_rst_mp", mpc, 0);
    chk("mid_rst_ev", ev, 0);
    for (int i = 0; i < 16; i++) begin
      fpc = 32'(i * 4);
      #1;
      chk("mid_rst_fp", fp, 0);
    end
    tick;
    reset = 1'b0;
    fpc = 32'h10;
    #1;
    chk("post_rst_fp", fp, 0);

    a1 = 16'd3; b1 = 16'd3; op1 = 4'd0; v1 = 1; st1 = 0;
    pc1 = 16'hFFFC; imm1 = 16'h0; pr1 = 0; fpc1 = 16'h000C;
    #1;
    chk("w16_tgt", 32'(tgt1), 32'h0);
    chk("w16_cmp", cmp1, 1);
    chk("w16_mp", mp1, 1);
    chk("w16_fp_pre", fp1, 0);
    tick;
    v1 = 0;
    #1;
    chk("w16_fp_idx3", fp1, 1);
    fpc1 = 16'hFF0C;
    #1;
    chk("w16_fp_alias", fp1, 1);
    fpc1 = 16'h0008;
    #1;
    chk("w16_fp_idx2", fp1, 0);
    chk("w16_br", brc1, 1);

    repeat (2) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
